// File: rtl/data_bus_responder.sv
// Data-side memory responder for the TinuC core: word RAM plus a small
// peripheral window (GPIO and a compare timer). Reads are combinational
// from daddr and current state; writes land on the rising CLK edge.
module data_bus_responder #(
  parameter int RAM_WORDS = 128,
  parameter int GPIO_W    = 8
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [9:0]        daddr,
  input  logic              d_rw,
  input  logic [31:0]       ddata_w,
  output logic [31:0]       ddata_r,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              irq
);

  // Word offsets (daddr[9:2]) of the peripheral registers.
  localparam logic [7:0] OFF_GPIO_OUT = 8'h80;
  localparam logic [7:0] OFF_GPIO_IN  = 8'h81;
  localparam logic [7:0] OFF_TCNT     = 8'h82;
  localparam logic [7:0] OFF_TCMP     = 8'h83;
  localparam logic [7:0] OFF_TCTRL    = 8'h84;
  localparam logic [7:0] OFF_TSTAT    = 8'h85;

  localparam int          RAM_AW      = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [31:0] RAM_WORDS_U = 32'(RAM_WORDS);

  // Storage.
  logic [31:0]       ram_r [RAM_WORDS];
  logic [GPIO_W-1:0] gpio_out_r;
  logic [GPIO_W-1:0] sync1_r;
  logic [GPIO_W-1:0] sync2_r;
  logic [31:0]       tcnt_r;
  logic [31:0]       tcmp_r;
  logic [2:0]        tctrl_r;   // bit0 EN, bit1 AUTOCLR, bit2 IRQEN
  logic              match_r;
  logic              irq_r;

  // Decode helpers.
  logic [7:0]        word_s;
  logic [6:0]        ram_idx_s;
  logic [RAM_AW-1:0] ram_addr_s;
  logic              ram_sel_s;
  logic              periph_sel_s;

  // Write strobes and next-state values.
  logic              we_ram_s;
  logic              we_gpo_s;
  logic              we_tcnt_s;
  logic              we_tcmp_s;
  logic              we_tctrl_s;
  logic              we_tstat_s;
  logic              hit_s;
  logic [31:0]       tcnt_nxt_s;
  logic              match_nxt_s;
  logic [2:0]        tctrl_nxt_s;
  logic [31:0]       gpo_ext_s;
  logic [31:0]       gpi_ext_s;

  assign word_s       = daddr[9:2];
  assign ram_idx_s    = daddr[8:2];
  assign ram_addr_s   = ram_idx_s[RAM_AW-1:0];
  assign ram_sel_s    = (daddr[9] == 1'b0) && (32'(ram_idx_s) < RAM_WORDS_U);
  assign periph_sel_s = (daddr[9] == 1'b1);

  // Zero-extend the GPIO registers to bus width.
  always_comb begin
    gpo_ext_s = 32'd0;
    gpi_ext_s = 32'd0;
    gpo_ext_s[GPIO_W-1:0] = gpio_out_r;
    gpi_ext_s[GPIO_W-1:0] = sync2_r;
  end

  // Decode write strobes for the addressed target.
  always_comb begin
    we_ram_s   = 1'b0;
    we_gpo_s   = 1'b0;
    we_tcnt_s  = 1'b0;
    we_tcmp_s  = 1'b0;
    we_tctrl_s = 1'b0;
    we_tstat_s = 1'b0;
    if (d_rw && ram_sel_s) begin
      we_ram_s = 1'b1;
    end else if (d_rw && periph_sel_s) begin
      case (word_s)
        OFF_GPIO_OUT: we_gpo_s   = 1'b1;
        OFF_TCNT:     we_tcnt_s  = 1'b1;
        OFF_TCMP:     we_tcmp_s  = 1'b1;
        OFF_TCTRL:    we_tctrl_s = 1'b1;
        OFF_TSTAT:    we_tstat_s = 1'b1;
        default:      we_ram_s   = 1'b0;
      endcase
    end else begin
      we_ram_s = 1'b0;
    end
  end

  // Timer next state: a bus write to TCNT beats both increment and auto-clear;
  // the compare always uses the pre-write count.
  always_comb begin
    hit_s       = tctrl_r[0] && (tcnt_r == tcmp_r);
    tcnt_nxt_s  = tcnt_r;
    match_nxt_s = match_r;
    tctrl_nxt_s = tctrl_r;
    if (we_tcnt_s) begin
      tcnt_nxt_s = ddata_w;
    end else if (!tctrl_r[0]) begin
      tcnt_nxt_s = tcnt_r;
    end else if (hit_s && tctrl_r[1]) begin
      tcnt_nxt_s = 32'd0;
    end else begin
      tcnt_nxt_s = tcnt_r + 32'd1;
    end
    if (hit_s) begin
      match_nxt_s = 1'b1;
    end else if (we_tstat_s && ddata_w[0]) begin
      match_nxt_s = 1'b0;
    end else begin
      match_nxt_s = match_r;
    end
    if (we_tctrl_s) begin
      tctrl_nxt_s = ddata_w[2:0];
    end else begin
      tctrl_nxt_s = tctrl_r;
    end
  end

  // Combinational read mux; no read side effects.
  always_comb begin
    ddata_r = 32'd0;
    if (ram_sel_s) begin
      ddata_r = ram_r[ram_addr_s];
    end else if (periph_sel_s) begin
      case (word_s)
        OFF_GPIO_OUT: ddata_r = gpo_ext_s;
        OFF_GPIO_IN:  ddata_r = gpi_ext_s;
        OFF_TCNT:     ddata_r = tcnt_r;
        OFF_TCMP:     ddata_r = tcmp_r;
        OFF_TCTRL:    ddata_r = {29'd0, tctrl_r};
        OFF_TSTAT:    ddata_r = {31'd0, match_r};
        default:      ddata_r = 32'd0;
      endcase
    end else begin
      ddata_r = 32'd0;
    end
  end

  // RAM write port; contents are intentionally not reset.
  always_ff @(posedge CLK) begin
    if (we_ram_s) begin
      ram_r[ram_addr_s] <= ddata_w;
    end
  end

  // Peripheral registers, GPIO synchronizer and registered irq.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      gpio_out_r <= '0;
      sync1_r    <= '0;
      sync2_r    <= '0;
      tcnt_r     <= 32'd0;
      tcmp_r     <= 32'hFFFF_FFFF;
      tctrl_r    <= 3'd0;
      match_r    <= 1'b0;
      irq_r      <= 1'b0;
    end else begin
      sync1_r <= gpio_in;
      sync2_r <= sync1_r;
      if (we_gpo_s) begin
        gpio_out_r <= ddata_w[GPIO_W-1:0];
      end
      if (we_tcmp_s) begin
        tcmp_r <= ddata_w;
      end
      tcnt_r  <= tcnt_nxt_s;
      tctrl_r <= tctrl_nxt_s;
      match_r <= match_nxt_s;
      // irq tracks MATCH & IRQEN of the state being loaded on this edge.
      irq_r   <= match_nxt_s & tctrl_nxt_s[2];
    end
  end

  assign gpio_out = gpio_out_r;
  assign irq      = irq_r;

endmodule

// File: tb/tb_data_bus_responder.sv
// Self-checking bench for data_bus_responder: directed test-plan steps
// followed by randomized bus traffic checked against a behavioural model.
module tb_data_bus_responder;

  localparam int RAM_WORDS = 128;
  localparam int GPIO_W    = 8;

  logic              CLK;
  logic              RESET_N;
  logic [9:0]        daddr;
  logic              d_rw;
  logic [31:0]       ddata_w;
  logic [31:0]       ddata_r;
  logic [GPIO_W-1:0] gpio_in;
  logic [GPIO_W-1:0] gpio_out;
  logic              irq;

  int n_cmp = 0;
  int n_mis = 0;

  data_bus_responder #(.RAM_WORDS(RAM_WORDS), .GPIO_W(GPIO_W)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .daddr(daddr), .d_rw(d_rw),
    .ddata_w(ddata_w), .ddata_r(ddata_r), .gpio_in(gpio_in),
    .gpio_out(gpio_out), .irq(irq)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Reference model state.
  logic [31:0]       m_ram [RAM_WORDS];
  logic [GPIO_W-1:0] m_gpo, m_s1, m_s2;
  logic [31:0]       m_tcnt, m_tcmp;
  logic [2:0]        m_ctrl;
  logic              m_match;

  task automatic mreset();
    m_gpo = '0; m_s1 = '0; m_s2 = '0;
    m_tcnt = 32'd0; m_tcmp = 32'hFFFF_FFFF; m_ctrl = 3'd0; m_match = 1'b0;
  endtask

  function automatic logic [31:0] mread(input logic [9:0] a);
    int off;
    off = int'(a) / 4;
    if (off < 128) return (off < RAM_WORDS) ? m_ram[off] : 32'd0;
    case (off)
      128: return 32'(m_gpo);
      129: return 32'(m_s2);
      130: return m_tcnt;
      131: return m_tcmp;
      132: return 32'(m_ctrl);
      133: return 32'(m_match);
      default: return 32'd0;
    endcase
  endfunction

  // Advance the model across one rising edge with the given bus inputs.
  task automatic mstep(input logic [9:0] a, input logic rw, input logic [31:0] w);
    int  off;
    bit  en, hit;
    logic [31:0] nt;
    off = int'(a) / 4;
    en  = m_ctrl[0];
    hit = en && (m_tcnt == m_tcmp);
    if (rw && off == 130)        nt = w;
    else if (!en)                nt = m_tcnt;
    else if (hit && m_ctrl[1])   nt = 32'd0;
    else                         nt = m_tcnt + 32'd1;
    if (hit) m_match = 1'b1;
    else if (rw && off == 133 && w[0]) m_match = 1'b0;
    m_tcnt = nt;
    if (rw && off < RAM_WORDS) m_ram[off] = w;
    if (rw && off == 128) m_gpo = w[GPIO_W-1:0];
    if (rw && off == 131) m_tcmp = w;
    if (rw && off == 132) m_ctrl = w[2:0];
    m_s2 = m_s1;
    m_s1 = gpio_in;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus cycle. mode 0: no read check, 1: check vs model, 2: check vs exp.
  task automatic step(input logic [9:0] a, input logic rw, input logic [31:0] w,
                      input int mode, input logic [31:0] exp, input string tag);
    daddr = a; d_rw = rw; ddata_w = w;
    @(negedge CLK);
    if (mode == 1) check({tag, "_model"}, ddata_r, mread(a));
    else if (mode == 2) check(tag, ddata_r, exp);
    if (mode != 0) begin
      check({tag, "_irq"}, 32'(irq), 32'(m_match && m_ctrl[2]));
      check({tag, "_gpo"}, 32'(gpio_out), 32'(m_gpo));
    end
    mstep(a, rw, w);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [9:0]  a;
    logic [31:0] w;
    int r;
    RESET_N = 1'b0; daddr = 10'd0; d_rw = 1'b0; ddata_w = 32'd0; gpio_in = '0;
    mreset();
    repeat (3) @(posedge CLK);
    #1;
    RESET_N = 1'b1;

    // Reset values.
    step(10'h200, 1'b0, 32'd0, 2, 32'd0,        "rst_gpo");
    step(10'h208, 1'b0, 32'd0, 2, 32'd0,        "rst_tcnt");
    step(10'h20C, 1'b0, 32'd0, 2, 32'hFFFFFFFF, "rst_tcmp");
    step(10'h214, 1'b0, 32'd0, 2, 32'd0,        "rst_tstat");
    check("rst_irq", 32'(irq), 32'd0);

    // Give every RAM word a known value.
    for (int i = 0; i < RAM_WORDS; i++) step(10'(i * 4), 1'b1, $urandom, 0, 32'd0, "pre");

    // RAM.
    step(10'h004, 1'b1, 32'hDEADBEEF, 1, 32'd0, "ram_w0");
    step(10'h1FC, 1'b1, 32'h12345678, 1, 32'd0, "ram_w1");
    step(10'h004, 1'b0, 32'd0, 2, 32'hDEADBEEF, "ram_r0");
    step(10'h1FC, 1'b0, 32'd0, 2, 32'h12345678, "ram_r1");
    step(10'h007, 1'b0, 32'd0, 2, 32'hDEADBEEF, "ram_unal");
    step(10'h3FC, 1'b1, 32'hCAFEF00D, 1, 32'd0, "unmap_w");
    step(10'h3FC, 1'b0, 32'd0, 2, 32'd0, "unmap_r");

    // GPIO.
    step(10'h200, 1'b1, 32'hFFFFFFA5, 1, 32'd0, "gpo_w");
    check("gpo_pin", 32'(gpio_out), 32'h000000A5);
    step(10'h200, 1'b0, 32'd0, 2, 32'h000000A5, "gpo_r");
    gpio_in = 8'h3C;
    step(10'h204, 1'b0, 32'd0, 2, 32'd0, "gpi_e0");
    step(10'h204, 1'b0, 32'd0, 2, 32'd0, "gpi_e1");
    step(10'h204, 1'b0, 32'd0, 2, 32'h3C, "gpi_e2");

    // Timer auto-clear.
    step(10'h20C, 1'b1, 32'd5, 1, 32'd0, "tcmp_w");
    step(10'h210, 1'b1, 32'h7, 1, 32'd0, "tctrl_w");
    for (int i = 0; i <= 5; i++) step(10'h208, 1'b0, 32'd0, 2, 32'(i), "tcnt_cnt");
    #1;
    check("irq_set", 32'(irq), 32'd1);
    step(10'h214, 1'b0, 32'd0, 2, 32'd1, "match_set");
    step(10'h208, 1'b0, 32'd0, 2, 32'd1, "tcnt_aclr");
    step(10'h214, 1'b1, 32'd1, 1, 32'd0, "w1c");
    #1;
    check("irq_clr", 32'(irq), 32'd0);

    // Wrap and MATCH set-wins.
    step(10'h210, 1'b1, 32'd0, 1, 32'd0, "stop");
    step(10'h20C, 1'b1, 32'd3, 1, 32'd0, "tcmp3");
    step(10'h208, 1'b1, 32'hFFFFFFFE, 1, 32'd0, "tcnt_w");
    step(10'h214, 1'b1, 32'd1, 1, 32'd0, "w1c2");
    step(10'h210, 1'b1, 32'd1, 1, 32'd0, "en");
    step(10'h208, 1'b0, 32'd0, 2, 32'hFFFFFFFE, "wrap0");
    step(10'h208, 1'b0, 32'd0, 2, 32'hFFFFFFFF, "wrap1");
    step(10'h208, 1'b0, 32'd0, 2, 32'd0,        "wrap2");
    step(10'h208, 1'b0, 32'd0, 2, 32'd1,        "wrap3");
    step(10'h214, 1'b0, 32'd0, 2, 32'd0,        "match_pre");
    step(10'h214, 1'b1, 32'd1, 2, 32'd0,        "setwin_cyc");
    step(10'h214, 1'b0, 32'd0, 2, 32'd1,        "setwin");

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 3);
      if (r < 2) a = 10'($urandom_range(0, 127) * 4 + $urandom_range(0, 3));
      else if (r == 2) a = 10'(32'h200 + $urandom_range(0, 6) * 4);
      else a = 10'(32'h200 + $urandom_range(0, 255));
      w = $urandom;
      if (a[9] && (a[7:2] == 6'h02 || a[7:2] == 6'h03)) w = 32'($urandom_range(0, 24));
      if ($urandom_range(0, 7) == 0) gpio_in = 8'($urandom);
      step(a, 1'($urandom_range(0, 1)), w, 1, 32'd0, "rnd");
    end

    // Asynchronous reset in the middle of a write while the timer runs.
    step(10'h20C, 1'b1, 32'd2, 1, 32'd0, "pre_rst_cmp");
    step(10'h210, 1'b1, 32'h7, 1, 32'd0, "pre_rst_ctrl");
    step(10'h208, 1'b1, 32'd0, 1, 32'd0, "pre_rst_cnt");
    repeat (4) step(10'h208, 1'b0, 32'd0, 1, 32'd0, "run");
    daddr = 10'h200; d_rw = 1'b1; ddata_w = 32'h5A;
    #3;
    RESET_N = 1'b0;
    #1;
    check("mrst_gpo", 32'(gpio_out), 32'd0);
    check("mrst_irq", 32'(irq), 32'd0);
    check("mrst_rd_gpo", ddata_r, 32'd0);
    daddr = 10'h20C;
    #1;
    check("mrst_rd_tcmp", ddata_r, 32'hFFFFFFFF);
    daddr = 10'h208;
    #1;
    check("mrst_rd_tcnt", ddata_r, 32'd0);
    @(posedge CLK);
    #1;
    d_rw = 1'b0;
    RESET_N = 1'b1;
    mreset();
    step(10'h200, 1'b0, 32'd0, 2, 32'd0, "post_rst_gpo");
    step(10'h208, 1'b0, 32'd0, 2, 32'd0, "post_rst_tcnt");
    step(10'h214, 1'b0, 32'd0, 2, 32'd0, "post_rst_tstat");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/data_bus_responder.md
Name: data_bus_responder

Overview:
- Data-side memory responder for the pipelined TinuC core: the target of the core's daddr / d_rw / ddata_w / ddata_r bus.
- Decodes the 10-bit byte address into a word RAM and a small memory-mapped peripheral window (GPIO plus a compare timer).
- Returns read data combinationally in the same cycle, so the core's MEM→WB register captures it at the end of MEM.
- Performs writes on the rising clock edge.

Parameters:
- RAM_WORDS, 128, number of 32-bit RAM words; must be ≤128 so the RAM fits in daddr[8:2].
- GPIO_W, 8, width of the GPIO input and output ports (1..32).

Ports:
- CLK  input  1  clock
- RESET_N  input  1  reset, asynchronous, active-low
- daddr  input  10  byte address from the core; daddr[1:0] ignored (word accesses only)
- d_rw  input  1  write enable; 1 = write ddata_w at the rising edge
- ddata_w  input  32  write data
- ddata_r  output  32  read data, combinational from daddr
- gpio_in  input  GPIO_W  asynchronous external inputs
- gpio_out  output  GPIO_W  GPIO output register
- irq  output  1  timer interrupt request, level

Behaviour:
- Address map (word offset = daddr[9:2]):
  - daddr[9]=0: RAM word daddr[8:2]. Indices ≥ RAM_WORDS read 0; writes to them are ignored.
  - 0x200 GPIO_OUT: RW, low GPIO_W bits.
  - 0x204 GPIO_IN: RO, synchronized value, zero-extended.
  - 0x208 TCNT: RW.
  - 0x20C TCMP: RW.
  - 0x210 TCTRL: RW, bit0 EN, bit1 AUTOCLR, bit2 IRQEN; other bits read 0.
  - 0x214 TSTAT: bit0 MATCH, sticky; writing 1 to bit0 clears it.
  - Any other 0x2xx offset reads 0; writes are ignored.
- Reads:
  - ddata_r is a pure function of daddr and the current state, valid in the same cycle, independent of d_rw.
  - No read side effects; reading TSTAT does not clear it.
- Writes:
  - Take effect at the rising CLK edge when d_rw=1.
  - A read of the same address in that cycle shows the pre-edge value; the next cycle shows the new value.
- RAM: not reset. Contents are undefined until written.
- Reset values: gpio_out=0, TCNT=0, TCMP=0xFFFFFFFF, TCTRL=0, MATCH=0, irq=0, both synchronizer stages=0. Reset applies immediately and asynchronously, even mid-write.
- GPIO_IN: two-flop synchronizer. A change on gpio_in is visible in ddata_r after the 2nd rising edge.
- Timer, evaluated each edge:
  - hit = EN & (TCNT == TCMP).
  - If d_rw writes TCNT, the written value wins over increment and auto-clear.
  - Else if EN=0, TCNT holds.
  - Else if hit & AUTOCLR, TCNT ← 0.
  - Else TCNT ← TCNT+1, wrapping 0xFFFFFFFF → 0 with no flag.
- MATCH:
  - Set on any edge where hit=1.
  - Cleared by a write to TSTAT with ddata_w[0]=1.
  - If set and clear occur in the same edge, set wins (MATCH=1).
  - A write with bit0=0 has no effect.
- Comparison uses TCNT before any same-cycle write to TCNT.
- irq = MATCH & IRQEN, registered-state driven (no combinational path from daddr).
- Register writes of TCMP/TCTRL take effect for the comparison on the following edge.

Test Plan:
- Reset, then read 0x200, 0x208, 0x20C, 0x214 → ddata_r = 0, 0, 0xFFFFFFFF, 0; irq=0.
- RAM access:
  - Write 0xDEADBEEF at 0x004 and 0x12345678 at 0x1FC, then read back → exact values.
  - Read 0x007 (unaligned) → 0xDEADBEEF.
  - Write 0x3FC (unmapped) → ignored; reads 0.
- GPIO:
  - Write 0xFFFFFFA5 to 0x200 → gpio_out=0xA5 (GPIO_W=8).
  - Drive gpio_in=0x3C → 0x204 reads 0 after 1 edge and 0x3C after 2 edges.
- Timer auto-clear:
  - Write TCMP=5, TCTRL=0x7 → TCNT counts 0..5 then 0.
  - MATCH=1 and irq=1 from the edge after TCNT==5.
  - Write 1 to 0x214 → irq drops next cycle.
- Timer wrap and MATCH priority:
  - Write TCNT=0xFFFFFFFE with EN=1, AUTOCLR=0, TCMP=3 → TCNT goes 0xFFFFFFFF, 0, 1.
  - W1C on TSTAT in the same cycle TCNT==3 → MATCH stays 1.
- Reset mid-operation: assert RESET_N low between edges while the timer runs and d_rw=1 → all outputs return to reset values immediately; the pending write is not performed.
